// File: rtl/block_lock_132.sv
// ---------------------------------------------------------------------------
// block_lock_132
//
// Block-lock receiver for a 128b payload / 4b sync-header line code. Words
// come out of an upstream 132-bit async FIFO. The block hunts for a good
// sync-header alignment, requests 1-bit slips from the upstream gearbox
// while alignment is wrong, and declares lock after LOCK_CNT consecutive
// good headers. While locked, it forwards the payload of every good word and
// watches a sliding window of WIN_LEN words. Lock is dropped once BAD_MAX bad
// headers are seen inside one window.
//
// Parameters
//   LOCK_CNT  - consecutive good headers needed to declare lock (>= 2)
//   WIN_LEN   - locked monitoring window length, in valid words
//   BAD_MAX   - bad headers inside one window that drop lock
//   SLIP_WAIT - valid words discarded unchecked after each slip (>= 1)
//
// Ports
//   i_clk    in   1    link-layer read clock
//   i_rst    in   1    synchronous active-high reset
//   i_empty  in   1    upstream FIFO empty flag
//   o_ren    out  1    FIFO read enable (never back-pressures)
//   i_rdata  in   132  FIFO read data, [131:128] header, [127:0] payload
//   o_data   out  128  payload of an accepted word (holds between words)
//   o_ctrl   out  1    1 = control block (4'b1010), 0 = data block (4'b0101)
//   o_valid  out  1    o_data / o_ctrl valid this cycle
//   o_lock   out  1    block lock achieved
//   o_slip   out  1    one-cycle 1-bit slip request to the gearbox
//   o_err    out  1    one-cycle pulse per bad header seen while locked
// ---------------------------------------------------------------------------
module block_lock_132 #(
  parameter int unsigned LOCK_CNT  = 16,
  parameter int unsigned WIN_LEN   = 64,
  parameter int unsigned BAD_MAX   = 8,
  parameter int unsigned SLIP_WAIT = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_empty,
  output logic         o_ren,
  input  logic [131:0] i_rdata,
  output logic [127:0] o_data,
  output logic         o_ctrl,
  output logic         o_valid,
  output logic         o_lock,
  output logic         o_slip,
  output logic         o_err
);

  // Counter widths are sized so that each counter can hold its terminal
  // value; no counter ever needs to wrap.
  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int BAD_W  = $clog2(BAD_MAX + 1);
  localparam int WIN_W  = $clog2(WIN_LEN + 1);
  localparam int SLIP_W = $clog2(SLIP_WAIT + 1);

  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT);
  localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(BAD_MAX);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WIN_LEN);
  localparam logic [SLIP_W-1:0] SLIP_LAST = SLIP_W'(SLIP_WAIT);

  localparam logic [3:0] HDR_DATA = 4'b0101;
  localparam logic [3:0] HDR_CTRL = 4'b1010;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SLIPW  = 2'd1,
    VERIFY = 2'd2,
    LOCKED = 2'd3
  } state_t;

  state_t            state;
  logic              rvalid;
  logic [GOOD_W-1:0] good_cnt;
  logic [BAD_W-1:0]  bad_cnt;
  logic [WIN_W-1:0]  win_cnt;
  logic [SLIP_W-1:0] slip_cnt;

  logic [3:0]        hdr;
  logic              hdr_ctrl;
  logic              hdr_good;
  logic [GOOD_W-1:0] good_inc;
  logic [BAD_W-1:0]  bad_inc;
  logic [WIN_W-1:0]  win_inc;
  logic [SLIP_W-1:0] slip_inc;
  logic              lose_lock;
  logic              win_end;

  // The FIFO is drained whenever it has data; reset gates the read so no
  // word is popped and then lost inside the reset cycle.
  assign o_ren = !i_empty && !i_rst;

  // Header decode: only the two legal sync patterns count as good.
  assign hdr      = i_rdata[131:128];
  assign hdr_ctrl = (hdr == HDR_CTRL);
  assign hdr_good = hdr_ctrl || (hdr == HDR_DATA);

  // Next values of the counters for the word currently presented.
  // bad_inc saturates so the loss-of-lock compare can never be skipped.
  assign good_inc  = good_cnt + GOOD_W'(1);
  assign win_inc   = win_cnt + WIN_W'(1);
  assign slip_inc  = slip_cnt + SLIP_W'(1);
  assign bad_inc   = (bad_cnt == BAD_LAST) ? bad_cnt : bad_cnt + BAD_W'(1);

  // Loss of lock has priority over the window-end clear, so a window whose
  // last word is the BAD_MAX-th bad one still drops lock.
  assign lose_lock = !hdr_good && (bad_inc == BAD_LAST);
  assign win_end   = (win_inc == WIN_LAST);

  // Lock FSM. The FIFO returns data one cycle after the read, so rvalid is
  // the registered read enable and qualifies i_rdata. The state machine only
  // moves on valid words; an empty gap just freezes it. All outputs are
  // registered here; the pulses default low every cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= HUNT;
      rvalid   <= 1'b0;
      good_cnt <= '0;
      bad_cnt  <= '0;
      win_cnt  <= '0;
      slip_cnt <= '0;
      o_data   <= '0;
      o_ctrl   <= 1'b0;
      o_valid  <= 1'b0;
      o_lock   <= 1'b0;
      o_slip   <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      rvalid  <= o_ren;
      o_valid <= 1'b0;
      o_slip  <= 1'b0;
      o_err   <= 1'b0;

      if (rvalid) begin
        case (state)
          // Searching for alignment: one good header starts verification,
          // a bad one asks the gearbox to shift by one bit.
          HUNT: begin
            if (hdr_good) begin
              state    <= VERIFY;
              good_cnt <= GOOD_W'(1);
            end else begin
              o_slip   <= 1'b1;
              slip_cnt <= '0;
              state    <= SLIPW;
            end
          end

          // Words already in flight through the gearbox still carry the old
          // alignment, so a fixed number of them are dropped unchecked.
          SLIPW: begin
            if (slip_inc == SLIP_LAST) begin
              slip_cnt <= '0;
              state    <= HUNT;
            end else begin
              slip_cnt <= slip_inc;
            end
          end

          // Counting consecutive good headers. The word that completes the
          // run is already trusted and gets forwarded.
          VERIFY: begin
            if (hdr_good) begin
              if (good_inc == GOOD_LAST) begin
                state    <= LOCKED;
                o_lock   <= 1'b1;
                good_cnt <= '0;
                win_cnt  <= '0;
                bad_cnt  <= '0;
                o_valid  <= 1'b1;
                o_data   <= i_rdata[127:0];
                o_ctrl   <= hdr_ctrl;
              end else begin
                good_cnt <= good_inc;
              end
            end else begin
              o_slip   <= 1'b1;
              good_cnt <= '0;
              slip_cnt <= '0;
              state    <= SLIPW;
            end
          end

          // Locked: forward good words, flag bad ones, and police the
          // bad-header rate per window.
          LOCKED: begin
            if (hdr_good) begin
              o_valid <= 1'b1;
              o_data  <= i_rdata[127:0];
              o_ctrl  <= hdr_ctrl;
            end else begin
              o_err <= 1'b1;
            end

            if (lose_lock) begin
              o_slip   <= 1'b1;
              o_lock   <= 1'b0;
              win_cnt  <= '0;
              bad_cnt  <= '0;
              slip_cnt <= '0;
              state    <= SLIPW;
            end else if (win_end) begin
              win_cnt <= '0;
              bad_cnt <= '0;
            end else begin
              win_cnt <= win_inc;
              bad_cnt <= hdr_good ? bad_cnt : bad_inc;
            end
          end

          default: begin
            state <= HUNT;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_block_lock_132.sv
// ---------------------------------------------------------------------------
// tb_block_lock_132
//
// Directed bench for block_lock_132 with default parameters. The bench plays
// the upstream FIFO: a word popped in one cycle shows up on i_rdata in the
// next cycle; when nothing was popped, i_rdata carries an illegal header so
// any use of unqualified data is visible. Inputs change on the falling edge,
// outputs are sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_block_lock_132;

  localparam logic [3:0] HD = 4'b0101;
  localparam logic [3:0] HC = 4'b1010;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_empty = 1'b1;
  logic [131:0] i_rdata = '0;
  logic         o_ren;
  logic [127:0] o_data;
  logic         o_ctrl;
  logic         o_valid;
  logic         o_lock;
  logic         o_slip;
  logic         o_err;

  int n_checks = 0;
  int n_pass   = 0;

  logic         pend_v = 1'b0;
  logic [131:0] pend   = '0;

  typedef struct {
    logic       rst;
    logic       empty;
    logic [3:0] hdr;
    logic [7:0] tag;
    logic       ev;
    logic       ec;
    logic [7:0] etag;
    logic       cd;
    logic       el;
    logic       es;
    logic       ee;
  } vec_t;

  vec_t vecs[$];
  logic [3:0] bad_hdr [0:5];

  block_lock_132 dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_empty (i_empty),
    .o_ren   (o_ren),
    .i_rdata (i_rdata),
    .o_data  (o_data),
    .o_ctrl  (o_ctrl),
    .o_valid (o_valid),
    .o_lock  (o_lock),
    .o_slip  (o_slip),
    .o_err   (o_err)
  );

  // Free-running 10-unit clock.
  always #5 i_clk = ~i_clk;

  function automatic logic [127:0] payload(input logic [7:0] tag);
    return {16{tag}};
  endfunction

  // Single-bit comparison.
  task automatic checkBit(input string name, input logic got, input logic exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got %b expected %b", name, got, exp);
  endtask

  // Full output comparison. ctrl/data are only compared when a word is
  // expected, or when cd asks for the reset values (data 0, ctrl 0).
  task automatic checkOutput(input string name, input logic ev, input logic ec,
                             input logic [7:0] etag, input logic cd, input logic el,
                             input logic es, input logic ee, input logic ee_dc);
    logic ok;
    logic [127:0] exp_data;
    exp_data = ev ? payload(etag) : '0;
    ok = (o_valid === ev) && (o_lock === el) && (o_slip === es);
    if (!ee_dc) ok = ok && (o_err === ee);
    if (ev) ok = ok && (o_ctrl === ec) && (o_data === exp_data);
    if (cd) ok = ok && (o_ctrl === 1'b0) && (o_data === exp_data);
    n_checks++;
    if (ok) n_pass++;
    else $display("[TB] FAIL %s: got valid/ctrl/lock/slip/err=%b%b%b%b%b data=%h, expected %b%b%b%b%b data=%h",
                  name, o_valid, o_ctrl, o_lock, o_slip, o_err, o_data,
                  ev, ec, el, es, ee, exp_data);
  endtask

  // One clock cycle of stimulus: presents last cycle's popped word, drives
  // reset/empty, checks the combinational read enable, then steps the clock.
  task automatic applyStimulus(input logic rst, input logic empty,
                               input logic [3:0] hdr, input logic [7:0] tag);
    @(negedge i_clk);
    if (pend_v) i_rdata = pend;
    else        i_rdata = {4'b1111, 128'h0};
    i_rst   = rst;
    i_empty = empty;
    pend_v  = !empty && !rst;
    pend    = {hdr, payload(tag)};
    #1;
    checkBit("o_ren", o_ren, !empty && !rst);
    @(posedge i_clk);
    #1;
  endtask

  // A word followed by an empty cycle, so the outputs seen after the empty
  // cycle belong to exactly this word. The first cycle must be quiet.
  task automatic sendWord(input string name, input logic [3:0] hdr, input logic [7:0] tag,
                          input logic lock_before, input logic ev, input logic el,
                          input logic es, input logic ee, input logic ee_dc);
    applyStimulus(1'b0, 1'b0, hdr, tag);
    checkOutput({name, " gap"}, 1'b0, 1'b0, 8'h0, 1'b0, lock_before, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'h0, 8'h0);
    checkOutput(name, ev, (hdr == HC), tag, 1'b0, el, es, ee, ee_dc);
  endtask

  task automatic addVec(input logic rst, input logic empty, input logic [3:0] hdr,
                        input logic [7:0] tag, input logic ev, input logic ec,
                        input logic [7:0] etag, input logic cd, input logic el,
                        input logic es, input logic ee);
    vec_t v;
    v = '{rst, empty, hdr, tag, ev, ec, etag, cd, el, es, ee};
    vecs.push_back(v);
  endtask

  initial begin
    bad_hdr[0] = 4'b0000;
    bad_hdr[1] = 4'b1111;
    bad_hdr[2] = 4'b0110;
    bad_hdr[3] = 4'b1001;
    bad_hdr[4] = 4'b0100;
    bad_hdr[5] = 4'b1011;

    // Expectations in each row are the outputs after that row's clock edge;
    // a word popped in row k is judged at the edge of row k+1.
    // Reset, then 16 data headers: lock rises with the 16th word.
    addVec(1, 1, 4'h0, 8'd0,  0, 0, 8'd0,  1, 0, 0, 0);
    addVec(1, 1, 4'h0, 8'd0,  0, 0, 8'd0,  1, 0, 0, 0);
    addVec(0, 0, HD,   8'd1,  0, 0, 8'd0,  0, 0, 0, 0);
    for (int t = 2; t <= 16; t++)
      addVec(0, 0, HD, 8'(t), 0, 0, 8'd0,  0, 0, 0, 0);
    addVec(0, 0, HC,   8'd17, 1, 0, 8'd16, 0, 1, 0, 0);
    addVec(0, 0, 4'h0, 8'd18, 1, 1, 8'd17, 0, 1, 0, 0);
    addVec(0, 0, HD,   8'd19, 0, 0, 8'd0,  0, 1, 0, 1);
    addVec(0, 1, 4'h0, 8'd0,  1, 0, 8'd19, 0, 1, 0, 0);
    addVec(0, 1, 4'h0, 8'd0,  0, 0, 8'd0,  0, 1, 0, 0);
    addVec(0, 0, HD,   8'd20, 0, 0, 8'd0,  0, 1, 0, 0);
    addVec(0, 0, HD,   8'd21, 1, 0, 8'd20, 0, 1, 0, 0);
    // One-cycle reset while o_valid is high: in-flight word 21 is dropped.
    addVec(1, 0, HD,   8'd22, 0, 0, 8'd0,  1, 0, 0, 0);
    // Bad header in HUNT: single slip, then four bad words ignored
    // (with an empty gap in the middle), then HUNT accepts a good word.
    addVec(0, 0, 4'h0, 8'd23, 0, 0, 8'd0,  0, 0, 0, 0);
    addVec(0, 0, 4'h3, 8'd24, 0, 0, 8'd0,  0, 0, 1, 0);
    addVec(0, 0, 4'h3, 8'd25, 0, 0, 8'd0,  0, 0, 0, 0);
    addVec(0, 1, 4'h0, 8'd0,  0, 0, 8'd0,  0, 0, 0, 0);
    addVec(0, 0, 4'h3, 8'd26, 0, 0, 8'd0,  0, 0, 0, 0);
    addVec(0, 0, 4'h3, 8'd27, 0, 0, 8'd0,  0, 0, 0, 0);
    addVec(0, 0, HD,   8'd28, 0, 0, 8'd0,  0, 0, 0, 0);
    addVec(0, 0, 4'hF, 8'd29, 0, 0, 8'd0,  0, 0, 0, 0);
    // Bad header in VERIFY: slip pulse for one cycle only.
    addVec(0, 1, 4'h0, 8'd0,  0, 0, 8'd0,  0, 0, 1, 0);
    addVec(0, 1, 4'h0, 8'd0,  0, 0, 8'd0,  0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].empty, vecs[i].hdr, vecs[i].tag);
      checkOutput($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ec, vecs[i].etag,
                  vecs[i].cd, vecs[i].el, vecs[i].es, vecs[i].ee, 1'b0);
    end

    // Fresh reset, then lock with i_empty toggling every other cycle.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b1, 4'h0, 8'h0);
      checkOutput("reset2", 0, 0, 8'h0, 1, 0, 0, 0, 1'b0);
    end
    for (int k = 1; k <= 16; k++)
      sendWord($sformatf("verify%0d", k), HD, 8'(k), 1'b0,
               (k == 16), (k == 16), 1'b0, 1'b0, 1'b0);

    // Locked: window 1 has 7 bad headers including its 64th word, window 2
    // has 7 bad headers at its first 7 words, so lock is held. Window 3 then
    // takes 8 bad headers in a row and the 8th drops lock.
    for (int n = 1; n <= 136; n++) begin
      logic bad;
      logic last;
      logic [3:0] h;
      bad  = ((n % 10 == 0) && (n <= 60)) || (n == 64) ||
             ((n >= 65) && (n <= 71)) || (n >= 129);
      last = (n == 136);
      h    = bad ? bad_hdr[n % 6] : (n[0] ? HC : HD);
      if (!bad)
        sendWord($sformatf("locked%0d", n), h, 8'(n), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      else if (!last)
        sendWord($sformatf("locked%0d", n), h, 8'(n), 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      else
        sendWord($sformatf("unlock%0d", n), h, 8'(n), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/block_lock_132.md
BLOCK_LOCK_132 -- requirements
Module: block_lock_132

Interface
REQ-001 Parameter LOCK_CNT, default 16: consecutive good sync headers needed to declare lock.
REQ-002 Parameter WIN_LEN, default 64: monitoring window length while locked, in valid words.
REQ-003 Parameter BAD_MAX, default 8: bad headers within one window that cause loss of lock.
REQ-004 Parameter SLIP_WAIT, default 4: valid words discarded unchecked after each slip request.
REQ-005 i_clk, input, 1: single clock, link-layer read domain.
REQ-006 i_rst, input, 1: reset, synchronous and active-high.
REQ-007 i_empty, input, 1: upstream 132-bit async FIFO empty flag.
REQ-008 o_ren, output, 1: FIFO read enable.
REQ-009 i_rdata, input, 132: FIFO read data; [131:128] is the sync header and [127:0] is the payload.
REQ-010 o_data, output, 128: payload of an accepted word.
REQ-011 o_ctrl, output, 1: 1 = control block (header 4'b1010), 0 = data block (header 4'b0101).
REQ-012 o_valid, output, 1: o_data and o_ctrl are valid this cycle.
REQ-013 o_lock, output, 1: block lock achieved.
REQ-014 o_slip, output, 1: one-cycle pulse requesting a 1-bit slip from the upstream 128->132 gearbox.
REQ-015 o_err, output, 1: one-cycle pulse for a bad header received while locked.

Function
REQ-016 o_ren SHALL equal !i_empty && !i_rst, combinationally; the block never back-pressures the FIFO.
REQ-017 i_rdata SHALL be treated as valid exactly one cycle after o_ren was high (internal registered rvalid).
REQ-018 A header SHALL be good iff it is 4'b0101 or 4'b1010; every other value is bad.
REQ-019 The FSM SHALL have four states, HUNT, SLIPW, VERIFY and LOCKED, and SHALL change state only on valid words.
REQ-020 HUNT, good word: go to VERIFY with good_cnt = 1.
REQ-021 HUNT, bad word: pulse o_slip and go to SLIPW.
REQ-022 SLIPW: discard SLIP_WAIT valid words without checking them, then go to HUNT; an i_empty gap extends the wait.
REQ-023 VERIFY, good word: increment good_cnt; at good_cnt == LOCK_CNT go to LOCKED with win_cnt = 0 and bad_cnt = 0.
REQ-024 VERIFY, bad word: pulse o_slip, clear good_cnt and go to SLIPW.
REQ-025 LOCKED: every valid word SHALL increment win_cnt.
REQ-026 LOCKED, bad word: increment bad_cnt (saturating at BAD_MAX) and pulse o_err.
REQ-027 LOCKED: when bad_cnt reaches BAD_MAX, pulse o_slip, deassert o_lock and go to SLIPW in the same update.
REQ-028 Window end: the word taking win_cnt to WIN_LEN is counted first; win_cnt and bad_cnt then clear unless REQ-027 fired on that word.
REQ-029 o_lock SHALL be 1 exactly while the state is LOCKED, registered.
REQ-030 The good word completing LOCK_CNT SHALL itself be forwarded.
REQ-031 In LOCKED, a good word SHALL produce o_valid = 1 with o_data/o_ctrl registered one cycle after rvalid, i.e. two cycles after o_ren.
REQ-032 Bad words and all words outside LOCKED SHALL produce o_valid = 0; o_data holds its last value.
REQ-033 o_slip and o_err SHALL each be high for at most one cycle per offending word.
REQ-034 Counter widths: good_cnt and bad_cnt $clog2(max+1) bits, win_cnt $clog2(WIN_LEN+1) bits; no counter wraps unintentionally.

Reset
REQ-035 When i_rst is sampled high, at the next edge: state = HUNT; all counters = 0; rvalid = 0; o_valid, o_lock, o_slip, o_err = 0; o_data = 0; o_ctrl = 0.
REQ-036 Reset asserted mid-operation SHALL discard any in-flight word, and o_ren SHALL be 0 while i_rst is high.

Verification
REQ-037 Stream of 16 words with header 4'b0101 after reset -> o_lock rises with the 16th word; that word appears on o_valid 2 cycles after its o_ren.
REQ-038 Header 4'b0000 in HUNT -> o_slip is a single pulse; the next 4 valid words are ignored; HUNT resumes.
REQ-039 Locked, then 7 bad words within a 64-word window -> 7 o_err pulses and o_lock stays 1; the 8th bad word in the same window -> o_slip pulse and o_lock = 0.
REQ-040 Locked, 7 bad words in window 1 and 7 in window 2 -> lock is held, including when the 64th word of a window is bad.
REQ-041 i_empty toggled every other cycle during VERIFY -> lock is reached after exactly 16 good valid words, and o_ren mirrors !i_empty.
REQ-042 i_rst pulsed for 1 cycle while LOCKED with o_valid high -> all outputs are 0 on the next cycle and the block re-enters HUNT.
